// File: rtl/cube_pkg.sv
// Shared types for the keyboard-to-rotation-engine move path: face
// encoding, rotation command, keycode constants and the keycode decoder.
package cube_pkg;

   typedef enum logic [2:0] {
      FACE_U          = 3'd0,
      FACE_D          = 3'd1,
      FACE_L          = 3'd2,
      FACE_R          = 3'd3,
      FACE_F          = 3'd4,
      FACE_B          = 3'd5,
      FACE_RESET_CUBE = 3'd6
   } face_t;

   typedef struct packed {
      face_t face;
      logic  ccw;
   } rot_cmd_t;

   typedef enum logic [1:0] {
      DEC_INVALID = 2'd0,
      DEC_CMD     = 2'd1,
      DEC_FLUSH   = 2'd2
   } dec_kind_t;

   typedef struct packed {
      dec_kind_t kind;
      rot_cmd_t  cmd;
   } decode_t;

   // Sequencer FSM; state_q inside the top is the observable state.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } seq_state_t;

   // USB HID keycodes: letters turn clockwise, digits 1-6 turn counter-clockwise.
   localparam logic [7:0] KEY_U_CW       = 8'h18;
   localparam logic [7:0] KEY_D_CW       = 8'h07;
   localparam logic [7:0] KEY_L_CW       = 8'h0F;
   localparam logic [7:0] KEY_R_CW       = 8'h15;
   localparam logic [7:0] KEY_F_CW       = 8'h09;
   localparam logic [7:0] KEY_B_CW       = 8'h05;
   localparam logic [7:0] KEY_U_CCW      = 8'h1E;
   localparam logic [7:0] KEY_D_CCW      = 8'h1F;
   localparam logic [7:0] KEY_L_CCW      = 8'h20;
   localparam logic [7:0] KEY_R_CCW      = 8'h21;
   localparam logic [7:0] KEY_F_CCW      = 8'h22;
   localparam logic [7:0] KEY_B_CCW      = 8'h23;
   localparam logic [7:0] KEY_RESET_CUBE = 8'h2C;
   localparam logic [7:0] KEY_FLUSH      = 8'h29;

   // Map a keycode to a command, a flush request, or invalid.
   function automatic decode_t decode_key(input logic [7:0] key);
      decode_t res;
      res.kind     = DEC_CMD;
      res.cmd.face = FACE_U;
      res.cmd.ccw  = 1'b0;
      case (key)
         KEY_U_CW:       res.cmd.face = FACE_U;
         KEY_D_CW:       res.cmd.face = FACE_D;
         KEY_L_CW:       res.cmd.face = FACE_L;
         KEY_R_CW:       res.cmd.face = FACE_R;
         KEY_F_CW:       res.cmd.face = FACE_F;
         KEY_B_CW:       res.cmd.face = FACE_B;
         KEY_U_CCW:      begin res.cmd.face = FACE_U; res.cmd.ccw = 1'b1; end
         KEY_D_CCW:      begin res.cmd.face = FACE_D; res.cmd.ccw = 1'b1; end
         KEY_L_CCW:      begin res.cmd.face = FACE_L; res.cmd.ccw = 1'b1; end
         KEY_R_CCW:      begin res.cmd.face = FACE_R; res.cmd.ccw = 1'b1; end
         KEY_F_CCW:      begin res.cmd.face = FACE_F; res.cmd.ccw = 1'b1; end
         KEY_B_CCW:      begin res.cmd.face = FACE_B; res.cmd.ccw = 1'b1; end
         KEY_RESET_CUBE: res.cmd.face = FACE_RESET_CUBE;
         KEY_FLUSH:      res.kind = DEC_FLUSH;
         default:        res.kind = DEC_INVALID;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/move_fifo.sv
// DEPTH-entry synchronous FIFO of rotation commands. Pointers wrap modulo
// DEPTH (power of two); occupancy is a separate 0..DEPTH counter. Flush wins
// over push on the same edge; push when full and pop when empty are ignored.
module move_fifo
   import cube_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  rot_cmd_t               push_data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output rot_cmd_t               pop_data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);

   rot_cmd_t      mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full_o     = (count_q == (AW+1)'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pop_data_o = mem_q[rd_ptr_q];

   // Next pointers and occupancy; flush clears everything.
   always_comb begin
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/move_sequencer.sv
// Consumes keyboard move strobes, decodes keycodes into face rotations,
// buffers them and issues one at a time to the rotation engine, holding an
// animation interval after each accepted command.
// Handshake: rot_valid rises with a command and rot_face/rot_ccw stay stable
// until the edge where rot_valid && rot_ready; rot_valid is a pure function of
// registered state, so rot_ready never reaches it combinationally.
module move_sequencer
   import cube_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int ANIM_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   Reset_n,
   input  logic                   move_f,
   input  logic [7:0]             keycode_in,
   output logic                   rot_valid,
   output logic [2:0]             rot_face,
   output logic                   rot_ccw,
   input  logic                   rot_ready,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] queue_count,
   output logic [7:0]             drop_count
);

   localparam int HW = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(ANIM_CYCLES - 1);

   decode_t                dec;
   logic                   fifo_push, fifo_pop, fifo_flush;
   logic                   fifo_full, fifo_empty, drop_evt;
   rot_cmd_t               fifo_head;
   logic [$clog2(DEPTH):0] fifo_count;

   seq_state_t    state_q, state_d;
   rot_cmd_t      cmd_q, cmd_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [7:0]    drop_q, drop_d;

   move_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i       (clk),
      .rst_ni      (Reset_n),
      .push_i      (fifo_push),
      .push_data_i (dec.cmd),
      .pop_i       (fifo_pop),
      .flush_i     (fifo_flush),
      .pop_data_o  (fifo_head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Classify each strobe: enqueue, flush, or drop (full uses pre-edge occupancy).
   always_comb begin
      dec        = decode_key(keycode_in);
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      drop_evt   = 1'b0;
      if (move_f) begin
         case (dec.kind)
            DEC_CMD: begin
               if (fifo_full) drop_evt  = 1'b1;
               else           fifo_push = 1'b1;
            end
            DEC_FLUSH: fifo_flush = 1'b1;
            default:   drop_evt   = 1'b1;
         endcase
      end
      drop_d = (drop_evt && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next state: pop into the output register, wait for ready, count the hold.
   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      hold_d   = hold_q;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cmd_d    = fifo_head;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (rot_ready) begin
               hold_d  = HOLD_LOAD;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hold_q == '0) state_d = ST_IDLE;
            else              hold_d  = hold_q - HW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Command, hold counter and drop counter registers.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cmd_q  <= '0;
         hold_q <= '0;
         drop_q <= '0;
      end else begin
         cmd_q  <= cmd_d;
         hold_q <= hold_d;
         drop_q <= drop_d;
      end
   end

   // Outputs derived from registered state only.
   always_comb begin
      rot_valid   = (state_q == ST_ISSUE);
      rot_face    = cmd_q.face;
      rot_ccw     = cmd_q.ccw;
      busy        = (state_q != ST_IDLE) || !fifo_empty;
      queue_count = fifo_count;
      drop_count  = drop_q;
   end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: expected commands are queued as {face,ccw}
// when a strobe is issued; a negedge monitor pops and compares on every
// rot_valid && rot_ready. Directed checks cover counts, latency and timing.
module tb_move_sequencer;

   logic       clk = 1'b0;
   logic       Reset_n;
   logic       move_f;
   logic [7:0] keycode_in;
   logic       rot_valid;
   logic [2:0] rot_face;
   logic       rot_ccw;
   logic       rot_ready;
   logic       busy;
   logic [2:0] queue_count;
   logic [7:0] drop_count;

   logic [3:0] exp_q[$];
   logic [3:0] exp_e;
   int         chk_cnt = 0;
   int         pass_cnt = 0;
   int         hs_cnt = 0;

   move_sequencer #(.DEPTH(4), .ANIM_CYCLES(16)) dut (
      .clk         (clk),
      .Reset_n     (Reset_n),
      .move_f      (move_f),
      .keycode_in  (keycode_in),
      .rot_valid   (rot_valid),
      .rot_face    (rot_face),
      .rot_ccw     (rot_ccw),
      .rot_ready   (rot_ready),
      .busy        (busy),
      .queue_count (queue_count),
      .drop_count  (drop_count)
   );

   // Clock / reset: 10 ns period.
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      chk_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
   endtask

   // Driver tasks; every task leaves time at 1 ns after a rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [7:0] key);
      move_f     = 1'b1;
      keycode_in = key;
      tick(1);
      move_f     = 1'b0;
      keycode_in = 8'h00;
   endtask

   task automatic expect_cmd(input logic [2:0] face, input logic ccw);
      exp_q.push_back({face, ccw});
   endtask

   task automatic wait_idle(input string name, input int max);
      int n = 0;
      while (busy && n < max) begin
         tick(1);
         n++;
      end
      check(name, busy, 0);
   endtask

   // Scoreboard monitor: compare each handshaken command against the queue.
   always @(negedge clk) begin
      if (Reset_n && rot_valid && rot_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL spurious_cmd: got face=%0d ccw=%0d, required no command (t=%0t)",
                     rot_face, rot_ccw, $time);
         end else begin
            exp_e = exp_q.pop_front();
            check("cmd_face", rot_face, exp_e[3:1]);
            if (exp_e[3:1] != 3'd6) check("cmd_ccw", rot_ccw, exp_e[0]);
         end
      end
   end

   initial begin : stim
      int n;
      int hs0;
      logic stable;

      Reset_n    = 1'b0;
      move_f     = 1'b0;
      keycode_in = 8'h00;
      rot_ready  = 1'b0;
      tick(2);

      // Reset values.
      check("rst_valid", rot_valid, 0);
      check("rst_face", rot_face, 0);
      check("rst_ccw", rot_ccw, 0);
      check("rst_busy", busy, 0);
      check("rst_qcount", queue_count, 0);
      check("rst_drop", drop_count, 0);
      Reset_n = 1'b1;
      tick(1);

      // Single move: R clockwise, 2-edge latency, 16-cycle hold.
      rot_ready = 1'b1;
      expect_cmd(3'd3, 1'b0);
      strobe(8'h15);
      check("single_pre_valid", rot_valid, 0);
      check("single_qcount", queue_count, 1);
      tick(1);
      check("single_latency", rot_valid, 1);
      tick(1);
      check("single_valid_drop", rot_valid, 0);
      n = 0;
      while (busy && n < 40) begin
         n++;
         tick(1);
      end
      check("single_hold_len", n, 16);

      // CCW U then reset-cube; second valid 17 cycles after first handshake.
      expect_cmd(3'd0, 1'b1);
      expect_cmd(3'd6, 1'b0);
      strobe(8'h1E);
      strobe(8'h2C);
      check("ccw_first_valid", rot_valid, 1);
      tick(1);
      n = 0;
      while (!rot_valid && n < 60) begin
         tick(1);
         n++;
      end
      check("ccw_gap", n, 17);
      wait_idle("ccw_idle", 100);

      // Overflow: 6 strobes with ready low; 1 in flight + 4 queued, 1 dropped.
      rot_ready = 1'b0;
      hs0 = hs_cnt;
      expect_cmd(3'd0, 1'b0);
      expect_cmd(3'd1, 1'b0);
      expect_cmd(3'd2, 1'b0);
      expect_cmd(3'd3, 1'b0);
      expect_cmd(3'd4, 1'b0);
      strobe(8'h18);
      strobe(8'h07);
      strobe(8'h0F);
      strobe(8'h15);
      strobe(8'h09);
      strobe(8'h05);
      check("ovf_qcount", queue_count, 4);
      check("ovf_drop", drop_count, 1);
      check("ovf_inflight", rot_valid, 1);
      rot_ready = 1'b1;
      wait_idle("ovf_idle", 300);
      check("ovf_handshakes", hs_cnt - hs0, 5);

      // Invalid keycode: counted, nothing issued.
      hs0 = hs_cnt;
      strobe(8'h04);
      check("inv_drop", drop_count, 2);
      tick(3);
      check("inv_busy", busy, 0);
      check("inv_valid", rot_valid, 0);

      // Flush: 1 in flight + 3 queued, Esc empties the queue only.
      rot_ready = 1'b0;
      expect_cmd(3'd0, 1'b0);
      strobe(8'h18);
      strobe(8'h07);
      strobe(8'h0F);
      strobe(8'h15);
      check("flush_pre_qcount", queue_count, 3);
      strobe(8'h29);
      check("flush_qcount", queue_count, 0);
      check("flush_drop", drop_count, 2);
      check("flush_inflight", rot_valid, 1);
      check("flush_face", rot_face, 0);
      rot_ready = 1'b1;
      wait_idle("flush_idle", 100);
      check("flush_handshakes", hs_cnt - hs0, 1);

      // Backpressure: F ccw held stable for 10 cycles with ready low.
      rot_ready = 1'b0;
      hs0 = hs_cnt;
      expect_cmd(3'd4, 1'b1);
      strobe(8'h22);
      tick(1);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (!(rot_valid === 1'b1 && rot_face === 3'd4 && rot_ccw === 1'b1)) stable = 1'b0;
         tick(1);
      end
      check("bp_stable", stable, 1);
      check("bp_no_hs", hs_cnt - hs0, 0);
      rot_ready = 1'b1;
      tick(1);
      check("bp_hs_first_ready", hs_cnt - hs0, 1);
      check("bp_valid_drop", rot_valid, 0);
      wait_idle("bp_idle", 100);

      // Async reset mid-HOLD with one command still queued.
      expect_cmd(3'd5, 1'b1);
      strobe(8'h23);
      strobe(8'h18);
      tick(4);
      check("hold_busy", busy, 1);
      check("hold_qcount", queue_count, 1);
      check("hold_valid", rot_valid, 0);
      #2 Reset_n = 1'b0;
      #1;
      check("arst_valid", rot_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_qcount", queue_count, 0);
      check("arst_drop", drop_count, 0);
      check("arst_face", rot_face, 0);
      check("arst_ccw", rot_ccw, 0);
      exp_q.delete();
      tick(1);
      Reset_n = 1'b1;
      tick(1);
      expect_cmd(3'd4, 1'b0);
      strobe(8'h09);
      tick(1);
      check("post_rst_valid", rot_valid, 1);
      check("post_rst_face", rot_face, 4);
      wait_idle("post_rst_idle", 100);

      // Drop counter saturation with keycode 0 held for 260 strobes.
      move_f     = 1'b1;
      keycode_in = 8'h00;
      tick(260);
      move_f     = 1'b0;
      tick(1);
      check("drop_saturate", drop_count, 255);
      check("sat_qcount", queue_count, 0);

      tick(2);
      check("exp_q_empty", exp_q.size(), 0);

      // Final report.
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
